// File: rtl/mult_error_profiler.sv
// mult_error_profiler: sweeps every operand pair of a W-bit unsigned multiplier
// under test, compares each returned product with the exact one, and keeps
// error statistics (count, max/sum of absolute error, first failing pair).
module mult_error_profiler #(
    parameter int W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic [2*W-1:0]   dut_p,
    output logic             busy,
    output logic             done,
    output logic [2*W:0]     err_count,
    output logic [2*W-1:0]   max_abs_err,
    output logic [4*W-1:0]   sum_abs_err,
    output logic [W-1:0]     first_err_a,
    output logic [W-1:0]     first_err_b,
    output logic             first_err_vld
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2*W-1:0] IDX_LAST = '1;

    logic [1:0]     state;
    logic [2*W-1:0] idx;
    logic [2*W-1:0] exact;
    logic [2*W-1:0] diff;

    // The operand pair is the sweep index itself; op_b is the low half so it
    // varies fastest.
    assign op_a = idx[2*W-1:W];
    assign op_b = idx[W-1:0];

    // Operands are zero-extended so the product is formed at full 2W width.
    assign exact = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};

    // Absolute error as larger minus smaller, so it never wraps.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        diff = '0;
        if (dut_p >= exact) diff = dut_p - exact;
        else                diff = exact - dut_p;
    end

    // Sweep control and statistics accumulation, one operand pair per cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // in this block sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_count     <= '0;
            max_abs_err   <= '0;
            sum_abs_err   <= '0;
            first_err_a   <= '0;
            first_err_b   <= '0;
            first_err_vld <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // start wins over a simultaneous abort; abort alone is a no-op here.
                    if (start) begin
                        state         <= S_SWEEP;
                        idx           <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        err_count     <= '0;
                        max_abs_err   <= '0;
                        sum_abs_err   <= '0;
                        first_err_a   <= '0;
                        first_err_b   <= '0;
                        first_err_vld <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    if (abort) begin
                        // Partial statistics are left as they stand.
                        state <= S_IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        if (diff != '0) begin
                            err_count   <= err_count + {{(2*W){1'b0}}, 1'b1};
                            sum_abs_err <= sum_abs_err + {{(2*W){1'b0}}, diff};
                            if (diff > max_abs_err) max_abs_err <= diff;
                            if (!first_err_vld) begin
                                first_err_a   <= op_a;
                                first_err_b   <= op_b;
                                first_err_vld <= 1'b1;
                            end
                        end
                        // Terminal pair is accounted on the same edge that ends
                        // the sweep; the index is held rather than wrapped.
                        if (idx == IDX_LAST) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + {{(2*W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_error_profiler.sv
// Bench for mult_error_profiler (W=2): a stub multiplier with selectable
// error models, fixed-vector sweeps, random-LUT sweeps scored against a
// pair-by-pair reference, and the abort / restart / reset corner cases.
module tb_mult_error_profiler;

    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [1:0]   op_a, op_b;
    logic [3:0]   dut_p;
    logic         busy, done;
    logic [4:0]   err_count;
    logic [3:0]   max_abs_err;
    logic [7:0]   sum_abs_err;
    logic [1:0]   first_err_a, first_err_b;
    logic         first_err_vld;

    int           mode;
    logic [3:0]   lut [16];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int mode;
        int ec;
        int mx;
        int sm;
        int fa;
        int fb;
        int fv;
    } vec_t;

    vec_t tab [4];

    always #5 clk = ~clk;

    // Stub multiplier: mode 0 exact, 1-3 fixed faults, 4 arbitrary lookup table.
    function automatic logic [3:0] stub(input int m, input int a, input int b, input logic [3:0] l);
        int p;
        p = a * b;
        case (m)
            1: if (a == 2 && b == 1) p = 0;
            2: p = 0;
            3: begin
                if (a == 3 && b == 3) p = 10;
                if (a == 1 && b == 3) p = 0;
            end
            4: p = int'(l);
            default: ;
        endcase
        return 4'(p);
    endfunction

    assign dut_p = stub(mode, int'(op_a), int'(op_b), lut[{op_a, op_b}]);

    mult_error_profiler #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .op_a(op_a), .op_b(op_b), .dut_p(dut_p),
        .busy(busy), .done(done),
        .err_count(err_count), .max_abs_err(max_abs_err), .sum_abs_err(sum_abs_err),
        .first_err_a(first_err_a), .first_err_b(first_err_b), .first_err_vld(first_err_vld)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_stats(input string tag, input int ec, input int mx, input int sm,
                               input int fa, input int fb, input int fv);
        check({tag, ".err_count"},     32'(err_count),     ec);
        check({tag, ".max_abs_err"},   32'(max_abs_err),   mx);
        check({tag, ".sum_abs_err"},   32'(sum_abs_err),   sm);
        check({tag, ".first_err_vld"}, 32'(first_err_vld), fv);
        if (fv != 0) begin
            check({tag, ".first_err_a"}, 32'(first_err_a), fa);
            check({tag, ".first_err_b"}, 32'(first_err_b), fb);
        end
    endtask

    // Reference: walk all pairs in sweep order with plain integer arithmetic.
    task automatic ref_stats(output int ec, output int mx, output int sm,
                             output int fa, output int fb, output int fv);
        int p, e, d;
        ec = 0; mx = 0; sm = 0; fa = 0; fb = 0; fv = 0;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                p = int'(stub(mode, a, b, lut[a*4+b]));
                e = a * b;
                d = (p > e) ? p - e : e - p;
                if (d != 0) begin
                    ec++;
                    sm += d;
                    if (d > mx) mx = d;
                    if (fv == 0) begin fa = a; fb = b; fv = 1; end
                end
            end
        end
    endtask

    // Pulse start, then count busy cycles (bounded); optional mid-sweep start/abort.
    task automatic run_sweep(input int restart_at, input int abort_at, input bit abort_with_start,
                             output int cyc, output int ndone);
        @(posedge clk); #1;
        start = 1'b1; abort = abort_with_start;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        cyc = 0; ndone = 0;
        while (busy && cyc < 100) begin
            if (!done) ndone++;
            start = (cyc == restart_at);
            abort = (cyc == abort_at);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".op_a"}, 32'(op_a), 0);
        check({tag, ".op_b"}, 32'(op_b), 0);
        check({tag, ".first_err_a"}, 32'(first_err_a), 0);
        check({tag, ".first_err_b"}, 32'(first_err_b), 0);
        check_stats(tag, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int cyc, ndone;
        int ec, mx, sm, fa, fb, fv;

        tab[0] = '{0, 0, 0,  0, 0, 0, 0};
        tab[1] = '{1, 1, 2,  2, 2, 1, 1};
        tab[2] = '{2, 9, 9, 36, 1, 1, 1};
        tab[3] = '{3, 2, 3,  4, 1, 3, 1};

        for (int i = 0; i < 16; i++) lut[i] = 4'((i / 4) * (i % 4));
        mode  = 0;
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b0;
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Fixed vectors; sweeps after the first start from DONE.
        for (int i = 0; i < 4; i++) begin
            mode = tab[i].mode;
            run_sweep(-1, -1, 1'b0, cyc, ndone);
            check($sformatf("vec%0d.cycles", i), cyc, 16);
            check($sformatf("vec%0d.done", i), 32'(done), 1);
            check($sformatf("vec%0d.busy", i), 32'(busy), 0);
            if (i > 0) check($sformatf("vec%0d.done_low_cycles", i), ndone, 16);
            check_stats($sformatf("vec%0d", i), tab[i].ec, tab[i].mx, tab[i].sm,
                        tab[i].fa, tab[i].fb, tab[i].fv);
        end

        // Held outputs in DONE.
        repeat (3) @(posedge clk);
        #1;
        check("done_hold.done", 32'(done), 1);
        check_stats("done_hold", 2, 3, 4, 1, 3, 1);

        // Random lookup-table multipliers against the reference.
        for (int r = 0; r < 8; r++) begin
            mode = 4;
            for (int i = 0; i < 16; i++)
                lut[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'((i / 4) * (i % 4));
            ref_stats(ec, mx, sm, fa, fb, fv);
            run_sweep(-1, -1, 1'b0, cyc, ndone);
            check($sformatf("rand%0d.cycles", r), cyc, 16);
            check_stats($sformatf("rand%0d", r), ec, mx, sm, fa, fb, fv);
        end

        // start repeated at sweep cycle 5 is ignored.
        mode = 2;
        run_sweep(4, -1, 1'b0, cyc, ndone);
        check("restart.cycles", cyc, 16);
        check_stats("restart", 9, 9, 36, 1, 1, 1);

        // abort at sweep cycle 7.
        run_sweep(-1, 6, 1'b0, cyc, ndone);
        check("abort.cycles", cyc, 7);
        check("abort.busy", 32'(busy), 0);
        check("abort.done", 32'(done), 0);
        check("abort.op_a", 32'(op_a), 0);
        check("abort.op_b", 32'(op_b), 0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_idle.busy", 32'(busy), 0);

        // start together with abort in IDLE: start wins.
        mode = 1;
        run_sweep(-1, -1, 1'b1, cyc, ndone);
        check("start_abort.cycles", cyc, 16);
        check_stats("start_abort", 1, 2, 2, 2, 1, 1);

        // Reset asserted at sweep cycle 9, between clock edges.
        mode = 2;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("pre_reset.err_count", 32'(err_count), 3);
        check("pre_reset.op_a", 32'(op_a), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset.busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
